inst_fetch: RTL and testbench

Instruction fetch unit for the RV32I core. Generates sequential PCs, issues requests to instruction memory over a req/gnt + rvalid interface, and buffers returned words in order. Presents `{pc, inst}` to the decode/control stage with a valid/ready handshake. Redirects to the branch/jump target when the control stage reports `PC_ALU` for the instruction being consumed.

---
 rtl/inst_fetch.sv | 151 +++++++++++++++
 tb/tb_inst_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32I instruction fetch unit with in-order response buffer
package inst_fetch_pkg;
    typedef enum logic {PC_4 = 1'b0, PC_ALU = 1'b1} PCSel_e;
endpackage

module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_vld,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_inst_rdy,
    input  PCSel_e      i_pc_sel,
    input  logic [31:0] i_alu_res,
    output logic        o_misalign
);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_e;

    state_e          state_q;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, fill_ptr_q;
    logic [AW:0]     count_q, pend_q, drop_cnt_q, drop_cnt_d;
    logic            run_q, misalign_q;

    logic            pop, redirect, gnt_fire, fill;
    logic [AW+1:0]   occ_after_pop, outstanding_nxt;
    logic [AW:0]     count_d, pend_d;

    assign o_inst_vld  = (count_q != '0) && filled_q[rd_ptr_q];
    assign o_inst      = inst_mem_q[rd_ptr_q];
    assign o_pc        = pc_mem_q[rd_ptr_q];
    assign o_imem_addr = fetch_pc_q;
    assign o_misalign  = misalign_q;

    assign pop      = o_inst_vld && i_inst_rdy;
    assign redirect = pop && (i_pc_sel == PC_ALU);

    // Responses still owed to a flushed stream occupy memory-side capacity,
    // so they count against DEPTH alongside the allocated slots.
    assign occ_after_pop = {1'b0, count_q} + {1'b0, drop_cnt_q}
                         - {{(AW+1){1'b0}}, pop};
    assign o_imem_req    = run_q && (occ_after_pop < DEPTH_C);
    assign gnt_fire      = o_imem_req && i_imem_gnt;

    assign fill = i_imem_rvalid && (drop_cnt_q == '0) && !redirect;

    assign outstanding_nxt = {1'b0, drop_cnt_q} + {1'b0, pend_q}
                           + {{(AW+1){1'b0}}, gnt_fire}
                           - {{(AW+1){1'b0}}, i_imem_rvalid};

    assign count_d = count_q + {{AW{1'b0}}, gnt_fire} - {{AW{1'b0}}, pop};
    assign pend_d  = pend_q  + {{AW{1'b0}}, gnt_fire} - {{AW{1'b0}}, fill};

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            drop_cnt_d = outstanding_nxt[AW:0];
        end else if (i_imem_rvalid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_ONE;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = {i_alu_res[31:2], 2'b00};
        end else if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= FETCH;
            drop_cnt_q <= '0;
            misalign_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            drop_cnt_q <= drop_cnt_d;
            misalign_q <= redirect && (i_alu_res[1:0] != 2'b00);
            case (state_q)
                FETCH:   if (redirect && (drop_cnt_d != '0)) state_q <= DRAIN;
                DRAIN:   if (drop_cnt_d == '0) state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_ptr_q <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            filled_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (redirect) begin
                // A grant in the redirect cycle belongs to the old stream and is dropped too.
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                fill_ptr_q <= '0;
                count_q    <= '0;
                pend_q     <= '0;
                filled_q   <= '0;
            end else begin
                if (gnt_fire) begin
                    pc_mem_q[wr_ptr_q] <= fetch_pc_q;
                    filled_q[wr_ptr_q] <= 1'b0;
                    wr_ptr_q           <= wr_ptr_q + PTR_ONE;
                end
                if (fill) begin
                    inst_mem_q[fill_ptr_q] <= i_imem_rdata;
                    filled_q[fill_ptr_q]   <= 1'b1;
                    fill_ptr_q             <= fill_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                count_q <= count_d;
                pend_q  <= pend_d;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized self-checking bench for inst_fetch
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_inst_vld;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_inst_rdy;
    PCSel_e      i_pc_sel;
    logic [31:0] i_alu_res;
    logic        o_misalign;

    always #5 i_clk = ~i_clk;

    inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_inst_vld(o_inst_vld), .o_inst(o_inst), .o_pc(o_pc),
        .i_inst_rdy(i_inst_rdy), .i_pc_sel(i_pc_sel), .i_alu_res(i_alu_res),
        .o_misalign(o_misalign)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       mq[$];
    int          n_vec = 0, n_bad = 0;
    int          cyc = 0, epoch = 0, stale = 0, last_due = 0, drop_exp = 0;
    logic [31:0] exp_pc, exp_req;
    bit          redir_prev, mis_exp;

    logic        s_req, s_vld, s_mis, s_gfire, s_cons;
    logic [31:0] s_addr, s_pc, s_inst;
    int          s_cyc;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5EED_0003;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_pc     = RESET_PC;
        exp_req    = RESET_PC;
        redir_prev = 1'b0;
        mis_exp    = 1'b0;
        last_due   = 0;
        epoch++;
    endtask

    // One clock cycle: drive at the falling edge, sample 1ns later, update the model.
    task automatic step(input bit gnt, input bit rdy, input bit redir,
                        input logic [31:0] tgt, input int lat);
        i_imem_gnt    = gnt;
        i_inst_rdy    = rdy;
        i_pc_sel      = redir ? PC_ALU : PC_4;
        i_alu_res     = redir ? tgt : $urandom;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = $urandom;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = tag(mq[0].addr);
            if (mq[0].epoch != epoch) stale++;
            void'(mq.pop_front());
        end
        #1;
        s_cyc  = cyc;
        s_req  = o_imem_req;
        s_addr = o_imem_addr;
        s_vld  = o_inst_vld;
        s_pc   = o_pc;
        s_inst = o_inst;
        s_mis  = o_misalign;

        check_eq("misalign", 32'(s_mis), 32'(mis_exp));
        if (redir_prev) begin
            check_eq("vld_after_redirect", 32'(s_vld), 0);
            check_eq("req_after_redirect", 32'(s_req), 32'(drop_exp < DEPTH));
        end

        s_gfire = s_req & gnt;
        if (s_gfire) begin
            check_eq("req_addr", s_addr, exp_req);
            last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mq.push_back('{s_addr, last_due, epoch});
            exp_req = exp_req + 32'd4;
            check_eq("outstanding_le_depth", 32'(mq.size() <= DEPTH), 1);
        end

        s_cons     = s_vld & rdy;
        redir_prev = 1'b0;
        mis_exp    = 1'b0;
        if (s_cons) begin
            check_eq("o_pc", s_pc, exp_pc);
            check_eq("o_inst", s_inst, tag(exp_pc));
            if (redir) begin
                epoch++;
                exp_pc     = {tgt[31:2], 2'b00};
                exp_req    = {tgt[31:2], 2'b00};
                redir_prev = 1'b1;
                mis_exp    = (tgt[1:0] != 2'b00);
                drop_exp   = mq.size();
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n       = 1'b0;
        i_imem_rvalid = 1'b0;
        #1;
        check_eq("rst_vld", 32'(o_inst_vld), 0);
        check_eq("rst_req", 32'(o_imem_req), 0);
        check_eq("rst_misalign", 32'(o_misalign), 0);
        check_eq("rst_inst", o_inst, 0);
        check_eq("rst_pc", o_pc, 0);
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input int lat);
        bit done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step(1'b1, 1'b1, 1'b1, tgt, lat);
            done = s_cons;
        end
        check_eq("redirect_taken", 32'(done), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_g, first_v, gaps, grants, stale0;
        bit req_second;
        logic [31:0] hold_pc, hold_inst;
        bit have_hold;

        i_rst_n = 1'b0; i_imem_gnt = 1'b1; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        i_inst_rdy = 1'b1; i_pc_sel = PC_4; i_alu_res = '0;
        repeat (3) @(negedge i_clk);
        do_reset();

        // Reset release and back-to-back stream
        first_g = -1; first_v = -1; gaps = 0; req_second = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b1, 1'b0, '0, 1);
            if (i == 1) req_second = s_req;
            if (s_gfire && first_g < 0) first_g = s_cyc;
            if (first_v < 0) begin
                if (s_vld) first_v = s_cyc;
            end else if (!s_vld) begin
                gaps++;
            end
        end
        check_eq("first_req_after_release", 32'(req_second), 1);
        check_eq("first_vld_latency", 32'(first_v - first_g), 2);
        check_eq("stream_gaps", 32'(gaps), 0);

        // Backpressure from an empty unit
        do_reset();
        grants = 0; have_hold = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, 1);
            if (s_gfire) grants++;
            if (s_vld) begin
                if (have_hold) begin
                    check_eq("hold_pc", s_pc, hold_pc);
                    check_eq("hold_inst", s_inst, hold_inst);
                end else begin
                    hold_pc = s_pc; hold_inst = s_inst; have_hold = 1'b1;
                end
            end
        end
        check_eq("bp_grants", 32'(grants), DEPTH);
        check_eq("bp_req_low", 32'(s_req), 0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0, 1);

        // Redirect with three responses in flight, response and grant in the same cycle
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0, 3);
        stale0 = stale;
        redirect_to(32'h0000_0100, 3);
        check_eq("drop_outstanding", 32'(drop_exp), 3);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, '0, 3);
        check_eq("dropped_responses", 32'(stale - stale0), 3);

        // Misaligned target
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0, 1);
        redirect_to(32'h0000_0203, 1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 8, $urandom, int'($urandom_range(1, 4)));
        end

        // Reset while partly full
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0, 2);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, '0, 2);
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
